// File: rtl/sram_port_ctrl.sv
// Initiator for a single-port SRAM macro (CEB/WEB/A/D/Q, 1-cycle read): arbitrates
// write/read request channels onto the pins and buffers read data in a response FIFO.
module sram_port_ctrl #(
  parameter int DATA_W     = 64,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = 10,
  parameter int RESP_DEPTH = 3,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              w_valid_i,
  output logic              w_ready_o,
  input  logic [ADDR_W-1:0] w_addr_i,
  input  logic [DATA_W-1:0] w_data_i,
  input  logic              r_valid_i,
  output logic              r_ready_o,
  input  logic [ADDR_W-1:0] r_addr_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_data_o,
  output logic              init_done_o,
  output logic              sram_CEB_o,
  output logic              sram_WEB_o,
  output logic [ADDR_W-1:0] sram_A_o,
  output logic [DATA_W-1:0] sram_D_o,
  input  logic [DATA_W-1:0] sram_Q_i
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  localparam logic [0:0] S_INIT  = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;
  localparam logic [0:0] P_WRITE = 1'b0;
  localparam logic [0:0] P_READ  = 1'b1;

  localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(RESP_DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(RESP_DEPTH);
  localparam logic [CNT_W:0]    CREDIT_LIM = (CNT_W + 1)'(RESP_DEPTH);
  localparam logic [ADDR_W-1:0] INIT_LAST  = ADDR_W'(DEPTH - 1);

  logic [0:0]        state_q, state_d;
  logic [0:0]        prio_q, prio_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              inflight_q, inflight_d;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] fifo_mem_q [RESP_DEPTH];

  logic              wr_ok, rd_ok;
  logic              grant_w, grant_r;
  logic              push, pop;
  logic [CNT_W:0]    credit_used;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Reads reserve a FIFO slot at grant time, so a full FIFO blocks reads even when
  // the consumer is ready this cycle.
  assign credit_used = {1'b0, fifo_cnt_q} + {{CNT_W{1'b0}}, inflight_q};
  assign wr_ok       = w_valid_i;
  assign rd_ok       = r_valid_i && (credit_used < CREDIT_LIM);

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    prio_d     = prio_q;
    grant_w    = 1'b0;
    grant_r    = 1'b0;
    sram_CEB_o = 1'b1;
    sram_WEB_o = 1'b1;
    sram_A_o   = '0;
    sram_D_o   = '0;
    if (!reset_i) begin
      if (state_q == S_INIT) begin
        sram_CEB_o = 1'b0;
        sram_WEB_o = 1'b0;
        sram_A_o   = init_cnt_q;
        if (init_cnt_q == INIT_LAST) state_d = S_RUN;
        else                         init_cnt_d = init_cnt_q + ADDR_W'(1);
      end else begin
        if (wr_ok && rd_ok) begin
          grant_w = (prio_q == P_WRITE);
          grant_r = (prio_q == P_READ);
          prio_d  = ~prio_q;
        end else begin
          grant_w = wr_ok;
          grant_r = rd_ok;
        end
        if (grant_w) begin
          sram_CEB_o = 1'b0;
          sram_WEB_o = 1'b0;
          sram_A_o   = w_addr_i;
          sram_D_o   = w_data_i;
        end else if (grant_r) begin
          sram_CEB_o = 1'b0;
          sram_A_o   = r_addr_i;
        end
      end
    end
  end

  assign w_ready_o    = grant_w;
  assign r_ready_o    = grant_r;
  assign init_done_o  = (state_q == S_RUN);
  assign inflight_d   = grant_r;

  assign push         = inflight_q;
  assign pop          = resp_valid_o && resp_ready_i;
  assign resp_valid_o = (fifo_cnt_q != '0);
  assign resp_data_o  = fifo_mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= INIT_EN ? S_INIT : S_RUN;
      init_cnt_q <= '0;
      prio_q     <= P_WRITE;
      inflight_q <= 1'b0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      prio_q     <= prio_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // NOTE: FIFO storage is not reset; fifo_cnt_q alone decides which entries are live.
  always_ff @(posedge clock_i) begin
    if (push) fifo_mem_q[wr_ptr_q] <= sram_Q_i;
  end

  a_no_push_when_full: assert property (@(posedge clock_i) disable iff (reset_i)
    !(push && (fifo_cnt_q == CNT_FULL)));

endmodule
